// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state type, key map and helpers for the keypad scanner.
package keypad_pkg;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {SCAN, DEBOUNCE_PRESS, HELD, DEBOUNCE_RELEASE} state_t;

    // Indexed {row, col}; entry 0 is the top-left key.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic [1:0] lowest_low(input logic [NUM_ROWS-1:0] r);
        lowest_low = 2'd0;
        for (int i = NUM_ROWS - 1; i >= 0; i--)
            if (!r[i]) lowest_low = 2'(i);
    endfunction
endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: matrix lines plus the press/key level pair seen downstream.
interface keypad_scanner_if;
    logic [3:0] rows;
    logic [3:0] cols;
    logic       press;
    logic [3:0] key;

    modport master (input rows, output cols, press, key);
    modport slave  (output rows, input cols, press, key);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: 4-bit two-flop synchronizer for the row lines, idles high.
module sync_2ff (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d,
    output logic [3:0] q
);
    logic [3:0] m;

    always_ff @(posedge clk)
        if (!reset) {q, m} <= '1;
        else begin
            m <= d;
            q <= m;
        end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scans a 4x4 keypad, debounces one key and reports it as press/key.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input logic              clk,
    input logic              reset,
    keypad_scanner_if.master bus
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    state_t        state;
    logic [DW-1:0] dwell;
    logic [CW-1:0] cnt;
    logic [1:0]    col;
    logic [1:0]    row;
    logic [3:0]    rs;
    logic          tracked;

    sync_2ff u_sync (.clk(clk), .reset(reset), .d(bus.rows), .q(rs));

    assign tracked  = rs[row];
    assign bus.cols = ~(4'b0001 << col);

    // Counters stop one short of the terminal count; reaching it is the transition itself.
    always_ff @(posedge clk)
        if (!reset) begin
            state     <= SCAN;
            dwell     <= '0;
            cnt       <= '0;
            col       <= '0;
            row       <= '0;
            bus.press <= 1'b0;
            bus.key   <= '0;
        end else case (state)
            SCAN:
                if (dwell == DW'(SCAN_DIV - 1)) begin
                    dwell <= '0;
                    if (rs != '1) begin
                        row   <= lowest_low(rs);
                        cnt   <= '0;
                        state <= DEBOUNCE_PRESS;
                    end else col <= col + 2'd1;
                end else dwell <= dwell + 1'b1;
            DEBOUNCE_PRESS:
                if (tracked) begin
                    cnt   <= '0;
                    col   <= col + 2'd1;
                    state <= SCAN;
                end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt       <= '0;
                    bus.press <= 1'b1;
                    bus.key   <= KEY_MAP[{row, col}];
                    state     <= HELD;
                end else cnt <= cnt + 1'b1;
            HELD:
                if (tracked) begin
                    cnt   <= '0;
                    state <= DEBOUNCE_RELEASE;
                end
            DEBOUNCE_RELEASE:
                if (!tracked) begin
                    cnt   <= '0;
                    state <= HELD;
                end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt       <= '0;
                    bus.press <= 1'b0;
                    col       <= col + 2'd1;
                    dwell     <= '0;
                    state     <= SCAN;
                end else cnt <= cnt + 1'b1;
            default: state <= SCAN;
        endcase
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed and random key activity against a run-length keypad model.
module tb_keypad_scanner;
    localparam int S = 4;
    localparam int D = 8;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] held  = '0;
    int          total = 0;
    int          bad   = 0;
    bit          saw_press;

    keypad_scanner_if bus ();

    keypad_scanner #(.SCAN_DIV(S), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Physical keypad: a held key shorts its row to its column when that column is driven low.
    always_comb begin
        bus.rows = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (held[r*4+c] && !bus.cols[c]) bus.rows[r] = 1'b0;
    end

    bit         trk;
    int         mc, mp, mrow, run;
    logic       mpress;
    logic [3:0] mkey;
    logic [3:0] ms1, ms2;
    string      km = "123A456B789CE0FD";

    function automatic logic [3:0] hexof(int r, int c);
        byte ch;
        ch = km[r*4+c];
        return (ch <= "9") ? 4'(ch - "0") : 4'(ch - "A" + 10);
    endfunction

    // Press toggles on after D consecutive low samples from tracking start,
    // off after D+1 consecutive high samples while held.
    task automatic step();
        logic [3:0] rs;
        rs = ms2;
        if (!reset) begin
            trk = 0; mc = 0; mp = 0; mrow = 0; run = 0;
            mpress = 1'b0; mkey = 4'h0; ms1 = '1; ms2 = '1;
            return;
        end
        ms2 = ms1;
        ms1 = bus.rows;
        if (!trk) begin
            if (mp == S - 1) begin
                mp = 0;
                if (rs != 4'hF) begin
                    trk = 1;
                    run = 0;
                    for (int r = 3; r >= 0; r--) if (!rs[r]) mrow = r;
                end else mc = (mc + 1) % 4;
            end else mp++;
        end else if (!mpress) begin
            if (!rs[mrow]) begin
                run++;
                if (run == D) begin
                    mpress = 1'b1;
                    mkey = hexof(mrow, mc);
                    run = 0;
                end
            end else begin
                trk = 0; mc = (mc + 1) % 4; mp = 0; run = 0;
            end
        end else if (rs[mrow]) begin
            run++;
            if (run == D + 1) begin
                mpress = 1'b0; trk = 0; mc = (mc + 1) % 4; mp = 0; run = 0;
            end
        end else run = 0;
    endtask

    task automatic check();
        logic [3:0] ec;
        ec = 4'b1111 ^ (4'b0001 << mc);
        total++;
        assert (bus.cols === ec) else begin
            bad++; $error("FAIL cols got=%b exp=%b t=%0t", bus.cols, ec, $time);
        end
        total++;
        assert (bus.press === mpress) else begin
            bad++; $error("FAIL press got=%b exp=%b t=%0t", bus.press, mpress, $time);
        end
        total++;
        assert (bus.key === mkey) else begin
            bad++; $error("FAIL key got=%h exp=%h t=%0t", bus.key, mkey, $time);
        end
    endtask

    task automatic cycle();
        #1;
        step();
        @(negedge clk);
        check();
        if (bus.press) saw_press = 1;
    endtask

    task automatic run_n(int n);
        repeat (n) cycle();
    endtask

    task automatic chk(string tag, logic [3:0] got, logic [3:0] exp);
        total++;
        assert (got === exp) else begin
            bad++; $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_press(logic lvl);
        for (int n = 0; n < 200 && bus.press !== lvl; n++) cycle();
        total++;
        assert (bus.press === lvl) else begin
            bad++; $error("FAIL wait_press timeout got=%b exp=%b", bus.press, lvl);
        end
    endtask

    initial begin
        trk = 0; mc = 0; mp = 0; mrow = 0; run = 0;
        mpress = 1'b0; mkey = 4'h0; ms1 = '1; ms2 = '1;
        saw_press = 0;
        @(negedge clk);
        run_n(3);
        reset = 1'b1;
        run_n(20);

        held[1*4+2] = 1'b1;
        run_n(40);
        chk("hold_key6", bus.key, 4'h6);
        chk("hold_press", {3'b0, bus.press}, 4'h1);
        chk("hold_cols", bus.cols, 4'b1011);
        held = '0;
        run_n(30);
        chk("release_press", {3'b0, bus.press}, 4'h0);
        chk("release_key", bus.key, 4'h6);

        saw_press = 0;
        held[3*4+0] = 1'b1;
        run_n(5);
        held = '0;
        run_n(30);
        chk("short_nopress", {3'b0, saw_press}, 4'h0);
        chk("short_key", bus.key, 4'h6);

        held[0*4+3] = 1'b1;
        wait_press(1'b1);
        run_n(4);
        held = '0;
        run_n(3);
        held[0*4+3] = 1'b1;
        run_n(10);
        chk("bounce_press", {3'b0, bus.press}, 4'h1);
        chk("bounce_key", bus.key, 4'hA);
        held = '0;
        wait_press(1'b0);
        run_n(5);

        held[0*4+1] = 1'b1;
        held[2*4+1] = 1'b1;
        wait_press(1'b1);
        chk("multi_key", bus.key, 4'h2);
        held[0*4+0] = 1'b1;
        run_n(20);
        chk("second_key", bus.key, 4'h2);
        held = '0;
        wait_press(1'b0);
        run_n(10);

        held[1*4+1] = 1'b1;
        wait_press(1'b1);
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        chk("rst_press", {3'b0, bus.press}, 4'h0);
        chk("rst_key", bus.key, 4'h0);
        chk("rst_cols", bus.cols, 4'b1110);
        held = '0;
        run_n(10);

        repeat (40) begin
            held = '0;
            repeat ($urandom_range(0, 2)) held[$urandom_range(0, 15)] = 1'b1;
            run_n($urandom_range(1, 40));
        end
        held = '0;
        run_n(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
